// File: rtl/bin_morph_pkg.sv
// Shared types and constants for the binary morphology filter.
package bin_morph_pkg;

  typedef enum logic {
    DILATE = 1'b0,
    ERODE  = 1'b1
  } morph_mode_t;

  // Pipeline latency from input timing to output timing.
  localparam int unsigned LAT = 3;

  // Identity element of the reduction: 0 for OR (dilate), 1 for AND (erode).
  function automatic logic neutral(morph_mode_t m);
    return (m == ERODE);
  endfunction

endpackage

// File: rtl/bin_morph_if.sv
// 1-bit video stream: sync timing plus a binary pixel.
interface bin_morph_if;
  logic hs;
  logic vs;
  logic de;
  logic data;

  modport master (output hs, vs, de, data);
  modport slave  (input  hs, vs, de, data);
endinterface

// File: rtl/line_buf_bin.sv
// Line history RAM: one word per column, bit n holds the pixel from n+1 lines ago.
module line_buf_bin #(
  parameter int unsigned DEPTH = 480,
  parameter int unsigned LINES = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic             din,
  output logic [LINES-1:0] dout
);

  logic [LINES-1:0] mem [DEPTH];
  logic [LINES-1:0] word;

  assign word = mem[addr];

  // Registered read of the old word; a write pushes every line one step deeper.
  always_ff @(posedge clk) begin
    dout <= word;
    if (we) begin
      mem[addr] <= {word[LINES-2:0], din};
    end
  end

endmodule

// File: rtl/bin_morph.sv
// KxK binary dilate/erode with trailing window anchor and neutral out-of-frame taps.
module bin_morph
  import bin_morph_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned KSIZE    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  bin_morph_if.slave  vin,
  bin_morph_if.master vout
);

  localparam int unsigned CW    = $clog2(H_ACTIVE + 1);
  localparam int unsigned AW    = $clog2(H_ACTIVE);
  localparam int unsigned RW    = $clog2(KSIZE);
  localparam int unsigned LINES = KSIZE - 1;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("bin_morph: KSIZE must be 3 or 5");
  end

  logic          vs_p_q, de_p_q, frame_ok_q;
  morph_mode_t   active_q;
  logic [CW-1:0] col_q, col_d, col;
  logic [RW-1:0] row_q, row_d;
  logic          vs_rise, de_rise, de_fall, oversize, ok_now, lb_we;
  logic [AW-1:0] lb_addr;
  logic [LINES-1:0] lb_rd;

  logic          d1, ovs1, ovs2;
  logic [CW-1:0] col1, col2;
  logic [RW-1:0] row1, row2;
  morph_mode_t   mode1, mode2;
  logic [KSIZE-1:0][KSIZE-1:0] win_q;
  logic [KSIZE-1:0] col_vec;
  logic          data3, red, nv, tap, masked;
  logic [LAT-1:0] hs_sr, vs_sr, de_sr, ok_sr;

  // Edge detect, counter next state and line-buffer port.
  always_comb begin
    vs_rise  = vin.vs & ~vs_p_q;
    de_rise  = vin.de & ~de_p_q;
    de_fall  = ~vin.de & de_p_q;
    col      = de_rise ? '0 : col_q;
    oversize = (col >= CW'(H_ACTIVE));
    lb_we    = vin.de & ~oversize;
    lb_addr  = oversize ? '0 : col[AW-1:0];
    ok_now   = frame_ok_q | vs_rise;
    col_d    = col;
    if (lb_we) begin
      col_d = col + CW'(1);
    end
    row_d = row_q;
    if (vs_rise) begin
      row_d = '0;
    end else if (de_fall && row_q != RW'(KSIZE - 1)) begin
      row_d = row_q + RW'(1);
    end
  end

  // Counters, edge history, frame_ok and the frame-start mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_p_q     <= 1'b0;
      de_p_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      active_q   <= DILATE;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      vs_p_q     <= vin.vs;
      de_p_q     <= vin.de;
      frame_ok_q <= ok_now;
      col_q      <= col_d;
      row_q      <= row_d;
      if (vs_rise) begin
        active_q <= morph_mode_t'(mode);
      end
    end
  end

  line_buf_bin #(
    .DEPTH (H_ACTIVE),
    .LINES (LINES),
    .AW    (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .addr (lb_addr),
    .din  (vin.data),
    .dout (lb_rd)
  );

  // Column of taps entering the window: current pixel at row offset 0.
  assign col_vec = {lb_rd, d1};

  // Three-stage pixel pipeline alongside the sync delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
      ok_sr <= '0;
      d1    <= 1'b0;
      ovs1  <= 1'b0;
      col1  <= '0;
      row1  <= '0;
      mode1 <= DILATE;
      ovs2  <= 1'b0;
      col2  <= '0;
      row2  <= '0;
      mode2 <= DILATE;
      win_q <= '0;
      data3 <= 1'b0;
    end else begin
      hs_sr <= {hs_sr[LAT-2:0], vin.hs};
      vs_sr <= {vs_sr[LAT-2:0], vin.vs};
      de_sr <= {de_sr[LAT-2:0], vin.de};
      ok_sr <= {ok_sr[LAT-2:0], ok_now};
      d1    <= vin.data & vin.de;
      ovs1  <= oversize;
      col1  <= col;
      row1  <= row_q;
      mode1 <= active_q;
      ovs2  <= ovs1;
      col2  <= col1;
      row2  <= row1;
      mode2 <= mode1;
      if (de_sr[0]) begin
        for (int i = 0; i < int'(KSIZE); i++) begin
          win_q[i] <= {win_q[i][KSIZE-2:0], col_vec[i]};
        end
      end
      data3 <= red & de_sr[1];
    end
  end

  // Force out-of-frame taps to the neutral value, then OR/AND-reduce the window.
  always_comb begin
    nv     = neutral(mode2);
    red    = nv;
    tap    = nv;
    masked = 1'b0;
    for (int i = 0; i < int'(KSIZE); i++) begin
      for (int j = 0; j < int'(KSIZE); j++) begin
        masked = (int'(row2) < i) || (int'(col2) < j) || (ovs2 && (i != 0 || j != 0));
        tap    = masked ? nv : win_q[i][j];
        red    = (mode2 == ERODE) ? (red & tap) : (red | tap);
      end
    end
  end

  assign vout.hs   = hs_sr[LAT-1] & ok_sr[LAT-1];
  assign vout.vs   = vs_sr[LAT-1] & ok_sr[LAT-1];
  assign vout.de   = de_sr[LAT-1] & ok_sr[LAT-1];
  assign vout.data = data3 & ok_sr[LAT-1];

endmodule
